bt_uart_tx: RTL

Serialises status/fault message bytes (e.g. "FIM-CSU1-#") into 8N1 UART frames for the Bluetooth module.
- Sits directly downstream of the fault-detection message generator.
- Accepts bytes over a valid/ready handshake into a small FIFO, then shifts them out LSB-first on a single TX line.
- Flags completion of each frame and of each end-of-message character.

---
 rtl/bt_pkg.sv | 23 ++
 rtl/bt_byte_fifo.sv | 60 ++++++
 rtl/bt_uart_tx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bt_pkg.sv
// Shared UART framing constants and FSM state type for the Bluetooth TX path.
// No logic; compile-time definitions only.
// Also consumed by the fault-message generator for EOM and baud settings.
package bt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   UART_DATA_BITS = 8;

  localparam logic [7:0] EOM_CHAR_DEFAULT = 8'h23;  // '#'

  localparam int CLK_FREQ_HZ          = 50_000_000;
  localparam int BAUD_RATE            = 115_200;
  localparam int CLKS_PER_BIT_DEFAULT = CLK_FREQ_HZ / BAUD_RATE;  // 434

endpackage

// File: rtl/bt_byte_fifo.sv
// Single-clock show-ahead byte FIFO; rd_data is valid whenever empty is low.
// Latency: a write is visible on rd_data/empty one edge after it is taken.
// Backpressure: writes while full and reads while empty are ignored.
module bt_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_50M,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  // Full/empty come from the occupancy register; pointers wrap naturally.
  assign full    = (r_count == (PTR_W+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];
  assign w_do_wr = wr_en && !full;
  assign w_do_rd = rd_en && !empty;

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk_50M) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy update; simultaneous read and write keep count.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bt_uart_tx.sv
// 8N1 UART transmitter with input byte FIFO, LSB first, frame/EOM strobes.
// Latency: byte accepted at edge E0 into an idle, empty path drives start bit at E0+1.
// Backpressure: in_ready = !full from registered state; offers while full are dropped and latch overflow.
module bt_uart_tx
  import bt_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int         FIFO_DEPTH   = 16,
  parameter logic [7:0] EOM_CHAR     = EOM_CHAR_DEFAULT
) (
  input  logic                          clk_50M,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_done,
  output logic                          eom_sent
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      IDX_LAST = 3'(UART_DATA_BITS - 1);

  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [7:0]       w_fifo_rd_data;
  logic             w_push;
  logic             w_pop;

  tx_state_t        r_state;
  tx_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] w_bit_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       r_tx_byte;
  logic [7:0]       w_tx_byte_nxt;
  logic             r_tx;
  logic             w_tx_nxt;
  logic             r_overflow;

  assign in_ready = !w_fifo_full;
  assign w_push   = in_valid && in_ready;

  bt_byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_50M (clk_50M),
    .reset   (reset),
    .wr_en   (w_push),
    .wr_data (in_data),
    .rd_en   (w_pop),
    .rd_data (w_fifo_rd_data),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (fifo_count)
  );

  // Sticky record that an offered byte was dropped because the FIFO was full.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (in_valid && !in_ready) begin
      r_overflow <= 1'b1;
    end
  end

  // FSM state, bit timing counters, held byte and registered line driver.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_tx_byte <= '0;
      r_tx      <= UART_STOP_BIT;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_tx_byte <= w_tx_byte_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  // Next-state logic; the line value is computed one cycle ahead so uart_tx is a flop.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_tx_byte_nxt = r_tx_byte;
    w_tx_nxt      = r_tx;
    w_pop         = 1'b0;

    case (r_state)
      IDLE: begin
        w_tx_nxt = UART_STOP_BIT;
        if (!w_fifo_empty) begin
          w_pop         = 1'b1;
          w_tx_byte_nxt = w_fifo_rd_data;
          w_tx_nxt      = UART_START_BIT;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = START;
        end
      end

      START: begin
        if (r_bit_cnt == CNT_LAST) begin
          w_bit_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
          w_tx_nxt      = r_tx_byte[0];
          w_state_nxt   = DATA;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end

      DATA: begin
        if (r_bit_cnt == CNT_LAST) begin
          w_bit_cnt_nxt = '0;
          if (r_bit_idx == IDX_LAST) begin
            w_tx_nxt    = UART_STOP_BIT;
            w_state_nxt = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_tx_nxt      = r_tx_byte[w_bit_idx_nxt];
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end

      STOP: begin
        if (r_bit_cnt == CNT_LAST) begin
          w_bit_cnt_nxt = '0;
          // Chain straight into the next start bit when more bytes are queued.
          if (!w_fifo_empty) begin
            w_pop         = 1'b1;
            w_tx_byte_nxt = w_fifo_rd_data;
            w_tx_nxt      = UART_START_BIT;
            w_state_nxt   = START;
          end else begin
            w_tx_nxt    = UART_STOP_BIT;
            w_state_nxt = IDLE;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end

      default: begin
        w_tx_nxt    = UART_STOP_BIT;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Strobes are decodes of registered state, high for the last stop-bit cycle.
  assign uart_tx    = r_tx;
  assign tx_busy    = (r_state != IDLE);
  assign overflow   = r_overflow;
  assign frame_done = (r_state == STOP) && (r_bit_cnt == CNT_LAST);
  assign eom_sent   = frame_done && (r_tx_byte == EOM_CHAR);

endmodule
